led_pio_blink: RTL and testbench

//  Parametrised Avalon-MM output PIO for the alarm board LEDs/buzzer.

---
 rtl/led_pio_blink.sv | 101 ++++++++++
 tb/tb_led_pio_blink.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pio_blink.sv
// rtl/led_pio_blink.sv - Avalon-MM output PIO with atomic set/clear/toggle and per-channel blink
// Blink engine (MASK/PERIOD/STATUS registers) is built only when LED_PIO_BLINK_EN is defined.
module led_pio_blink #(
  parameter int unsigned      WIDTH          = 2,
  parameter int unsigned      PRESC_W        = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
  parameter logic [31:0]      DEFAULT_PERIOD = 32'd12500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_MASK   = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_SET    = 3'd4;
  localparam logic [2:0] ADDR_CLEAR  = 3'd5;
  localparam logic [2:0] ADDR_TOGGLE = 3'd6;

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_out;
  logic             unused_writedata;

  assign wr_en            = chipselect & ~write_n;
  assign wd               = writedata[WIDTH-1:0];
  assign unused_writedata = ^writedata;

  // Read-modify-write aliases let firmware flip one LED without racing an ISR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:   data_out <= wd;
        ADDR_SET:    data_out <= data_out | wd;
        ADDR_CLEAR:  data_out <= data_out & ~wd;
        ADDR_TOGGLE: data_out <= data_out ^ wd;
        default:     ;
      endcase
    end
  end

`ifdef LED_PIO_BLINK_EN
  logic [WIDTH-1:0]   mask;
  logic [PRESC_W-1:0] period;
  logic [PRESC_W-1:0] cnt;
  logic               phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask <= '0;
    end else if (wr_en && address == ADDR_MASK) begin
      mask <= wd;
    end
  end

  // A PERIOD write restarts the half-period so the new rate takes effect cleanly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period <= DEFAULT_PERIOD[PRESC_W-1:0];
      cnt    <= '0;
      phase  <= 1'b1;
    end else if (wr_en && address == ADDR_PERIOD) begin
      period <= writedata[PRESC_W-1:0];
      cnt    <= '0;
      phase  <= 1'b1;
    end else if (cnt == period) begin
      cnt    <= '0;
      phase  <= ~phase;
    end else begin
      cnt    <= cnt + PRESC_W'(1);
    end
  end

  assign out_port = data_out & (~mask | {WIDTH{phase}});
`else
  assign out_port = data_out;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0] = data_out;
`ifdef LED_PIO_BLINK_EN
      ADDR_MASK:   readdata[WIDTH-1:0] = mask;
      ADDR_PERIOD: readdata[PRESC_W-1:0] = period;
      ADDR_STATUS: readdata[0] = phase;
`endif
      default:     ;
    endcase
  end

endmodule

// File: tb/tb_led_pio_blink.sv
// tb/tb_led_pio_blink.sv - table-driven scoreboard bench for led_pio_blink
// Blink-engine expectations follow LED_PIO_BLINK_EN as seen by this compile.
module tb_led_pio_blink;

`ifdef LED_PIO_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  out_port;

  led_pio_blink #(
    .WIDTH(4), .PRESC_W(8), .RESET_VALUE(4'h5), .DEFAULT_PERIOD(32'd3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [2:0]  raddr;
    logic [31:0] exp_rd;
    logic [3:0]  exp_out;
  } vec_t;

  sb_t  sb[$];
  vec_t vt[13];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] act);
    sb_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got %h with nothing expected", act);
      return;
    end
    e = sb.pop_front();
    if (act !== e.exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
    end
  endtask

  task automatic check_rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    sb_push(name, exp);
    address = a;
    #1;
    sb_check(readdata);
  endtask

  task automatic check_out(input logic [3:0] exp, input string name);
    sb_push(name, {28'b0, exp});
    #1;
    sb_check({28'b0, out_port});
  endtask

  // Called just after a falling edge; returns at the next falling edge with the write committed.
  task automatic wr_reg(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;

    vt[0]  = '{1'b1, 1'b0, 3'd0, 32'hFFFF_FFFA, 3'd0, 32'hA, 4'hA};
    vt[1]  = '{1'b1, 1'b0, 3'd4, 32'h1,         3'd0, 32'hB, 4'hB};
    vt[2]  = '{1'b1, 1'b0, 3'd5, 32'h8,         3'd0, 32'h3, 4'h3};
    vt[3]  = '{1'b1, 1'b0, 3'd6, 32'h6,         3'd0, 32'h5, 4'h5};
    vt[4]  = '{1'b1, 1'b0, 3'd4, 32'hF,         3'd4, 32'h0, 4'hF};
    vt[5]  = '{1'b1, 1'b0, 3'd5, 32'h3,         3'd5, 32'h0, 4'hC};
    vt[6]  = '{1'b1, 1'b0, 3'd6, 32'hFFFF_FFF5, 3'd6, 32'h0, 4'h9};
    vt[7]  = '{1'b0, 1'b0, 3'd0, 32'h0,         3'd0, 32'h9, 4'h9};
    vt[8]  = '{1'b0, 1'b0, 3'd4, 32'hF,         3'd0, 32'h9, 4'h9};
    vt[9]  = '{1'b1, 1'b1, 3'd0, 32'h0,         3'd0, 32'h9, 4'h9};
    vt[10] = '{1'b1, 1'b0, 3'd7, 32'h0,         3'd7, 32'h0, 4'h9};
    vt[11] = '{1'b1, 1'b0, 3'd3, 32'h0,         3'd0, 32'h9, 4'h9};
    vt[12] = '{1'b1, 1'b0, 3'd0, 32'h5,         3'd0, 32'h5, 4'h5};

    repeat (2) @(negedge clk);
    check_out(4'h5, "reset_out");
    check_rd(3'd0, 32'h5, "reset_data");
    check_rd(3'd1, 32'h0, "reset_mask");
    check_rd(3'd2, BLINK ? 32'h3 : 32'h0, "reset_period");
    check_rd(3'd3, BLINK ? 32'h1 : 32'h0, "reset_status");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      sb_push($sformatf("vec%0d_rd", i), vt[i].exp_rd);
      sb_push($sformatf("vec%0d_out", i), {28'b0, vt[i].exp_out});
      wr_reg(vt[i].cs, vt[i].wn, vt[i].addr, vt[i].wd);
      address = vt[i].raddr;
      #1;
      sb_check(readdata);
      sb_check({28'b0, out_port});
    end

    if (BLINK) begin
      wr_reg(1'b1, 1'b0, 3'd0, 32'h1);
      wr_reg(1'b1, 1'b0, 3'd1, 32'h1);
      check_rd(3'd1, 32'h1, "mask_rd");
      wr_reg(1'b1, 1'b0, 3'd2, 32'h3);
      check_rd(3'd2, 32'h3, "period_rd");
      // out_port[0] high 4 clocks, low 4; MASK/DATA rewrites must not shift the pattern
      for (int k = 0; k < 16; k++) begin
        check_out(((k / 4) % 2 == 0) ? 4'h1 : 4'h0, $sformatf("blink3_k%0d", k));
        if (k == 5)      wr_reg(1'b1, 1'b0, 3'd1, 32'h1);
        else if (k == 9) wr_reg(1'b1, 1'b0, 3'd0, 32'h1);
        else             @(negedge clk);
      end

      wr_reg(1'b1, 1'b0, 3'd2, 32'h0);
      for (int k = 0; k < 6; k++) begin
        check_rd(3'd3, (k % 2 == 0) ? 32'h1 : 32'h0, $sformatf("p0_status_k%0d", k));
        @(negedge clk);
      end
      // phase=1 here and cnt==period: the write's restart must win over the toggle
      wr_reg(1'b1, 1'b0, 3'd2, 32'h0);
      check_rd(3'd3, 32'h1, "p0_rewrite_override");
      @(negedge clk);
      check_rd(3'd3, 32'h0, "p0_after_override");
      wr_reg(1'b1, 1'b0, 3'd2, 32'h5);
      for (int k = 0; k < 13; k++) begin
        check_rd(3'd3, ((k / 6) % 2 == 0) ? 32'h1 : 32'h0, $sformatf("p5_status_k%0d", k));
        @(negedge clk);
      end

      wr_reg(1'b1, 1'b0, 3'd0, 32'hF);
      wr_reg(1'b1, 1'b0, 3'd1, 32'hF);
      wr_reg(1'b1, 1'b0, 3'd2, 32'h3);
      check_out(4'hF, "midblink_high");
      repeat (4) @(negedge clk);
      check_out(4'h0, "midblink_low");
      #2;
      reset_n = 1'b0;
      check_out(4'h5, "async_reset_out");
      check_rd(3'd3, 32'h1, "async_reset_status");
      check_rd(3'd1, 32'h0, "async_reset_mask");
      check_rd(3'd2, 32'h3, "async_reset_period");
    end else begin
      wr_reg(1'b1, 1'b0, 3'd1, 32'hF);
      check_rd(3'd1, 32'h0, "nob_mask_rd");
      check_out(4'h5, "nob_out_after_mask");
      wr_reg(1'b1, 1'b0, 3'd2, 32'h7);
      check_rd(3'd2, 32'h0, "nob_period_rd");
      check_rd(3'd3, 32'h0, "nob_status_rd");
      wr_reg(1'b1, 1'b0, 3'd6, 32'hF);
      for (int k = 0; k < 8; k++) begin
        check_out(4'hA, $sformatf("nob_track_k%0d", k));
        @(negedge clk);
      end
      #2;
      reset_n = 1'b0;
      check_out(4'h5, "async_reset_out");
    end
    check_rd(3'd0, 32'h5, "async_reset_data");
    @(negedge clk);
    reset_n = 1'b1;

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
